// File: rtl/mem_arbiter_pkg.sv
// Shared widths and encodings for the fetch/data memory arbiter.
// These values match the core's global defines: 32-bit data, address and instruction words.
package mem_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int ADDR_SIZE  = 32;
   localparam int INSTR_SIZE = 32;

   // Wide enough for MEM_LAT-1 with MEM_LAT up to 4
   localparam int CNT_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// and data access, with at most one transaction outstanding of fixed latency MEM_LAT.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  i_req,
   input  logic [ADDR_SIZE-1:0]  i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [INSTR_SIZE-1:0] i_rdata,

   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [3:0]            d_amp,
   input  logic [XLEN-1:0]       d_addr,
   input  logic [XLEN-1:0]       d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [XLEN-1:0]       d_rdata,

   output logic                  m_en,
   output logic                  m_we,
   output logic [3:0]            m_amp,
   output logic [XLEN-1:0]       m_addr,
   output logic [XLEN-1:0]       m_wdata,
   input  logic [XLEN-1:0]       m_rdata
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   state_e            state;
   state_e            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   owner_e            owner;
   owner_e            owner_nxt;

   logic              done;
   logic              eligible;
   logic              gnt_i;
   logic              gnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         owner <= DATA;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         owner <= owner_nxt;
      end
   end

   // owner is both the holder of the outstanding transaction and the last grantee
   always_comb begin
      done      = 1'b0;
      eligible  = 1'b0;
      gnt_i     = 1'b0;
      gnt_d     = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      owner_nxt = owner;

      if (!reset) begin
         done     = (state == WAIT) && (cnt == '0);
         eligible = (state == IDLE) || done;

         if (eligible) begin
            if (i_req && d_req) begin
               gnt_i = (owner == DATA);
               gnt_d = (owner == FETCH);
            end else begin
               gnt_i = i_req;
               gnt_d = d_req;
            end
         end

         if (gnt_i || gnt_d) begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_LOAD;
            owner_nxt = gnt_d ? DATA : FETCH;
         end else if (done) begin
            state_nxt = IDLE;
         end else if (state == WAIT) begin
            cnt_nxt = cnt - 1'b1;
         end
      end
   end

   always_comb begin
      i_gnt   = gnt_i;
      d_gnt   = gnt_d;
      m_en    = gnt_i || gnt_d;
      m_we    = 1'b0;
      m_amp   = 4'b0000;
      m_addr  = '0;
      m_wdata = '0;

      if (gnt_d) begin
         m_we    = d_we;
         m_amp   = d_amp;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else if (gnt_i) begin
         m_addr  = XLEN'(i_addr);
      end

      i_rvalid = done && (owner == FETCH);
      d_rvalid = done && (owner == DATA);
      i_rdata  = i_rvalid ? INSTR_SIZE'(m_rdata) : '0;
      d_rdata  = d_rvalid ? m_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances with MEM_LAT = 1..4, directed scenarios plus
// randomized requesters, all checked against a timestamp-based transaction model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int NL = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                  i_req    [NL];
   logic [ADDR_SIZE-1:0]  i_addr   [NL];
   logic                  i_gnt    [NL];
   logic                  i_rvalid [NL];
   logic [INSTR_SIZE-1:0] i_rdata  [NL];
   logic                  d_req    [NL];
   logic                  d_we     [NL];
   logic [3:0]            d_amp    [NL];
   logic [XLEN-1:0]       d_addr   [NL];
   logic [XLEN-1:0]       d_wdata  [NL];
   logic                  d_gnt    [NL];
   logic                  d_rvalid [NL];
   logic [XLEN-1:0]       d_rdata  [NL];
   logic                  m_en     [NL];
   logic                  m_we     [NL];
   logic [3:0]            m_amp    [NL];
   logic [XLEN-1:0]       m_addr   [NL];
   logic [XLEN-1:0]       m_wdata  [NL];
   logic [XLEN-1:0]       m_rdata  [NL];

   for (genvar g = 0; g < NL; g++) begin : g_dut
      mem_arbiter #(.MEM_LAT(g + 1)) dut (
         .clk      (clk),
         .reset    (reset),
         .i_req    (i_req[g]),
         .i_addr   (i_addr[g]),
         .i_gnt    (i_gnt[g]),
         .i_rvalid (i_rvalid[g]),
         .i_rdata  (i_rdata[g]),
         .d_req    (d_req[g]),
         .d_we     (d_we[g]),
         .d_amp    (d_amp[g]),
         .d_addr   (d_addr[g]),
         .d_wdata  (d_wdata[g]),
         .d_gnt    (d_gnt[g]),
         .d_rvalid (d_rvalid[g]),
         .d_rdata  (d_rdata[g]),
         .m_en     (m_en[g]),
         .m_we     (m_we[g]),
         .m_amp    (m_amp[g]),
         .m_addr   (m_addr[g]),
         .m_wdata  (m_wdata[g]),
         .m_rdata  (m_rdata[g])
      );
   end

   int n_chk;
   int n_fail;

   task automatic chk(input string nm, input int l, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d (MEM_LAT=%0d) t=%0t: got 0x%0h, expected 0x%0h", nm, l, l + 1, $time, act, exp);
      end
   endtask

   // Model: a transaction granted in cycle t completes in cycle t + MEM_LAT.
   longint cyc;
   logic   busy   [NL];
   longint due    [NL];
   owner_e own    [NL];
   owner_e last   [NL];
   logic   own_we [NL];
   logic   ig_seen[NL];
   logic   dg_seen[NL];
   logic   md_done, md_elig, md_gi, md_gd, md_rvi, md_rvd;
   logic [63:0] md_addr;

   initial begin
      cyc = 0;
      for (int l = 0; l < NL; l++) begin
         busy[l] = 1'b0; due[l] = 0; own[l] = DATA; last[l] = DATA; own_we[l] = 1'b0;
         ig_seen[l] = 1'b0; dg_seen[l] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int l = 0; l < NL; l++) begin
            md_done = !reset && busy[l] && (cyc == due[l]);
            md_elig = !reset && (!busy[l] || md_done);
            md_gi = 1'b0;
            md_gd = 1'b0;
            if (md_elig && i_req[l] && d_req[l]) begin
               if (last[l] == FETCH) md_gd = 1'b1;
               else                  md_gi = 1'b1;
            end else if (md_elig) begin
               md_gi = i_req[l];
               md_gd = d_req[l];
            end
            md_rvi  = md_done && (own[l] == FETCH);
            md_rvd  = md_done && (own[l] == DATA);
            md_addr = md_gi ? 64'(i_addr[l]) : 64'(d_addr[l]);

            chk("i_gnt",    l, 64'(i_gnt[l]),    64'(md_gi));
            chk("d_gnt",    l, 64'(d_gnt[l]),    64'(md_gd));
            chk("m_en",     l, 64'(m_en[l]),     64'(md_gi | md_gd));
            chk("m_we",     l, 64'(m_we[l]),     64'(md_gd & d_we[l]));
            chk("m_amp",    l, 64'(m_amp[l]),    md_gd ? 64'(d_amp[l]) : 64'(0));
            if (md_gi || md_gd) begin
               chk("m_addr",  l, 64'(m_addr[l]),  md_addr);
               chk("m_wdata", l, 64'(m_wdata[l]), md_gd ? 64'(d_wdata[l]) : 64'(0));
            end else if (reset) begin
               chk("m_addr_rst",  l, 64'(m_addr[l]),  64'(0));
               chk("m_wdata_rst", l, 64'(m_wdata[l]), 64'(0));
            end
            chk("i_rvalid", l, 64'(i_rvalid[l]), 64'(md_rvi));
            chk("d_rvalid", l, 64'(d_rvalid[l]), 64'(md_rvd));
            chk("i_rdata",  l, 64'(i_rdata[l]),  md_rvi ? 64'(m_rdata[l]) : 64'(0));
            if (!md_rvd)
               chk("d_rdata_idle", l, 64'(d_rdata[l]), 64'(0));
            else if (!own_we[l])
               chk("d_rdata", l, 64'(d_rdata[l]), 64'(m_rdata[l]));

            ig_seen[l] = i_gnt[l];
            dg_seen[l] = d_gnt[l];

            if (reset) begin
               busy[l] = 1'b0;
               last[l] = DATA;
            end else if (md_gi || md_gd) begin
               busy[l]   = 1'b1;
               due[l]    = cyc + longint'(l + 1);
               own[l]    = md_gi ? FETCH : DATA;
               own_we[l] = md_gd & d_we[l];
               last[l]   = own[l];
            end else if (md_done) begin
               busy[l] = 1'b0;
            end
         end
         cyc++;
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      for (int l = 0; l < NL; l++) begin
         i_req[l] = 1'b0; i_addr[l] = '0;
         d_req[l] = 1'b0; d_we[l] = 1'b0; d_amp[l] = '0; d_addr[l] = '0; d_wdata[l] = '0;
         m_rdata[l] = '0;
      end
      repeat (3) @(posedge clk);
      #1;

      // Requests during reset must be ignored
      i_req[0] = 1'b1; d_req[0] = 1'b1;
      @(negedge clk);
      chk("rst_gnt",  0, 64'({i_gnt[0], d_gnt[0]}), 64'(0));
      chk("rst_m_en", 0, 64'(m_en[0]), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0; i_req[0] = 1'b0; d_req[0] = 1'b0;

      // Idle for five cycles
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("idle_m_en",  0, 64'(m_en[0]), 64'(0));
         chk("idle_m_amp", 0, 64'(m_amp[0]), 64'(0));
         chk("idle_gnt_rv", 0, 64'({i_gnt[0], d_gnt[0], i_rvalid[0], d_rvalid[0]}), 64'(0));
         @(posedge clk); #1;
      end

      // Single fetch, MEM_LAT=1
      i_req[0] = 1'b1; i_addr[0] = 32'h10; m_rdata[0] = 32'h0050_0093;
      @(negedge clk);
      chk("f1_i_gnt",  0, 64'(i_gnt[0]), 64'(1));
      chk("f1_m_en",   0, 64'(m_en[0]), 64'(1));
      chk("f1_m_addr", 0, 64'(m_addr[0]), 64'h10);
      @(posedge clk); #1;
      i_req[0] = 1'b0;
      @(negedge clk);
      chk("f1_i_rvalid", 0, 64'(i_rvalid[0]), 64'(1));
      chk("f1_i_rdata",  0, 64'(i_rdata[0]), 64'h0050_0093);
      @(posedge clk); #1;

      // Both request constantly after reset: FETCH first, then alternate
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      i_req[0] = 1'b1; i_addr[0] = 32'h14;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_i_gnt",    0, 64'(i_gnt[0]),    64'(k % 2 == 0));
         chk("rr_d_gnt",    0, 64'(d_gnt[0]),    64'(k % 2 == 1));
         chk("rr_i_rvalid", 0, 64'(i_rvalid[0]), 64'(k > 0 && k % 2 == 1));
         chk("rr_d_rvalid", 0, 64'(d_rvalid[0]), 64'(k > 0 && k % 2 == 0));
         chk("rr_m_addr",   0, 64'(m_addr[0]),   (k % 2 == 0) ? 64'h14 : 64'h40);
         @(posedge clk); #1;
      end
      i_req[0] = 1'b0; d_req[0] = 1'b0;
      @(negedge clk);
      chk("rr_tail_d_rvalid", 0, 64'(d_rvalid[0]), 64'(1));
      @(posedge clk); #1;

      // Fetch arrives in the data completion cycle while data stays requested
      d_req[0] = 1'b1; d_addr[0] = 32'h44; m_rdata[0] = 32'h1234;
      @(negedge clk);
      chk("bb_d_gnt0", 0, 64'(d_gnt[0]), 64'(1));
      @(posedge clk); #1;
      i_req[0] = 1'b1; i_addr[0] = 32'h18;
      @(negedge clk);
      chk("bb_i_gnt",    0, 64'(i_gnt[0]),    64'(1));
      chk("bb_d_gnt1",   0, 64'(d_gnt[0]),    64'(0));
      chk("bb_d_rvalid", 0, 64'(d_rvalid[0]), 64'(1));
      chk("bb_d_rdata",  0, 64'(d_rdata[0]),  64'h1234);
      @(posedge clk); #1;
      i_req[0] = 1'b0;
      @(negedge clk);
      chk("bb_d_gnt2",   0, 64'(d_gnt[0]),    64'(1));
      chk("bb_i_rvalid", 0, 64'(i_rvalid[0]), 64'(1));
      @(posedge clk); #1;
      d_req[0] = 1'b0;
      @(negedge clk);
      chk("bb_d_rvalid2", 0, 64'(d_rvalid[0]), 64'(1));
      @(posedge clk); #1;

      // Store on MEM_LAT=3 instance with a competing fetch
      d_req[2] = 1'b1; d_we[2] = 1'b1; d_amp[2] = 4'b0100; d_addr[2] = 32'h20; d_wdata[2] = 32'hAB;
      @(negedge clk);
      chk("st_d_gnt",   2, 64'(d_gnt[2]),   64'(1));
      chk("st_m_we",    2, 64'(m_we[2]),    64'(1));
      chk("st_m_amp",   2, 64'(m_amp[2]),   64'b0100);
      chk("st_m_addr",  2, 64'(m_addr[2]),  64'h20);
      chk("st_m_wdata", 2, 64'(m_wdata[2]), 64'hAB);
      @(posedge clk); #1;
      d_req[2] = 1'b0; d_we[2] = 1'b0; d_amp[2] = 4'b0000;
      i_req[2] = 1'b1; i_addr[2] = 32'h30;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("st_d_rvalid", 2, 64'(d_rvalid[2]), 64'(k == 3));
         chk("st_i_gnt",    2, 64'(i_gnt[2]),    64'(k == 3));
         chk("st_m_we_off", 2, 64'(m_we[2]),     64'(0));
         chk("st_m_amp_off", 2, 64'(m_amp[2]),   64'(0));
         @(posedge clk); #1;
      end
      i_req[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset one cycle after a fetch grant on MEM_LAT=2 instance
      i_req[1] = 1'b1; i_addr[1] = 32'h50;
      @(negedge clk);
      chk("rf_i_gnt0", 1, 64'(i_gnt[1]), 64'(1));
      @(posedge clk); #1;
      reset = 1'b1; i_req[1] = 1'b0;
      @(negedge clk);
      chk("rf_i_rvalid_rst", 1, 64'(i_rvalid[1]), 64'(0));
      chk("rf_m_en_rst",     1, 64'(m_en[1]),     64'(0));
      @(posedge clk); #1;
      reset = 1'b0; i_req[1] = 1'b1; i_addr[1] = 32'h54;
      @(negedge clk);
      chk("rf_i_gnt1",   1, 64'(i_gnt[1]),    64'(1));
      chk("rf_m_en",     1, 64'(m_en[1]),     64'(1));
      chk("rf_m_addr",   1, 64'(m_addr[1]),   64'h54);
      chk("rf_i_rvalid0", 1, 64'(i_rvalid[1]), 64'(0));
      @(posedge clk); #1;
      i_req[1] = 1'b0;
      @(negedge clk);
      chk("rf_i_rvalid1", 1, 64'(i_rvalid[1]), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rf_i_rvalid2", 1, 64'(i_rvalid[1]), 64'(1));
      @(posedge clk); #1;

      // Randomized requesters on all instances; fields held until granted
      for (int k = 0; k < 3000; k++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int l = 0; l < NL; l++) begin
            if (!i_req[l] || ig_seen[l]) begin
               i_req[l]  = ($urandom_range(0, 99) < 55);
               i_addr[l] = $urandom;
            end
            if (!d_req[l] || dg_seen[l]) begin
               d_req[l]   = ($urandom_range(0, 99) < 55);
               d_we[l]    = $urandom_range(0, 1);
               d_amp[l]   = 4'($urandom);
               d_addr[l]  = $urandom;
               d_wdata[l] = $urandom;
            end
            m_rdata[l] = $urandom;
         end
         @(posedge clk); #1;
      end

      reset = 1'b0;
      for (int l = 0; l < NL; l++) begin
         i_req[l] = 1'b0;
         d_req[l] = 1'b0;
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read/write latency in cycles from m_en to data/ack, legal range 1..4.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset. This is fixed: one clock, reset synchronous and active-high.
REQ-004 SHALL have the instruction-fetch port i_req in 1, i_addr in `ADDR_SIZE, i_gnt out 1, i_rvalid out 1, i_rdata out `INSTR_SIZE.
REQ-005 SHALL have the data port d_req in 1, d_we in 1, d_amp in 4, d_addr in `XLEN, d_wdata in `XLEN, d_gnt out 1, d_rvalid out 1, d_rdata out `XLEN.
REQ-006 SHALL have the memory port m_en out 1, m_we out 1, m_amp out 4, m_addr out `XLEN, m_wdata out `XLEN, m_rdata in `XLEN.

Function
REQ-007 SHALL share one single-ported memory between the fetch and data ports, with at most one transaction outstanding.
REQ-008 SHALL implement two states: IDLE (no outstanding transaction) and WAIT (transaction outstanding, latency counter running).
REQ-009 SHALL assert a grant only in IDLE, or in the WAIT cycle where the counter reaches 0 (the completion cycle).
- Grant and m_en are combinational in the grant cycle.
REQ-010 SHALL arbitrate when both ports request in a grant-eligible cycle by round-robin: grant the port not granted last.
- Last-owner register resets to DATA, so fetch wins the first tie.
REQ-011 SHALL grant a single request immediately, whatever the last-owner value.
REQ-012 SHALL, in the grant cycle, drive the memory port as follows:
- m_en=1.
- m_addr = granted address; fetch addresses are zero-extended to `XLEN.
- m_we = d_we for data, 0 for fetch.
- m_amp = d_amp for data, 4'b0000 for fetch.
- m_wdata = d_wdata for data, 0 for fetch.
REQ-013 SHALL hold m_en=0, m_we=0, m_amp=0 in every cycle without a grant.
REQ-014 SHALL load the counter with MEM_LAT-1 on grant, enter or stay in WAIT, and decrement the counter once per cycle in WAIT.
REQ-015 SHALL, in the completion cycle, pulse rvalid of the owning port for exactly one cycle, with rdata = m_rdata passed through.
- A write completion pulses d_rvalid as an acknowledge; d_rdata is don't-care.
REQ-016 SHALL go from the completion cycle back to IDLE if no grant is issued, else stay in WAIT with the new owner (back-to-back, one transaction per MEM_LAT cycles).
REQ-017 SHALL require requesters to hold req and their request fields stable until gnt; the arbiter never grants a port whose req is low.
REQ-018 SHALL drive i_rdata and d_rdata to 0 when the corresponding rvalid is 0.
REQ-019 SHALL forward d_amp unmodified, including illegal patterns; no alignment checking is done.

Reset
REQ-020 SHALL, while reset is high, force:
- state=IDLE, counter=0, last-owner=DATA.
- Outputs i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we = 0.
- m_amp = 0, m_addr = 0, m_wdata = 0.
REQ-021 SHALL drop any transaction outstanding at reset: no rvalid is issued for it after reset deasserts.
REQ-022 SHALL make grants possible from the first cycle after reset deasserts.

Structure
REQ-023 SHALL take `XLEN, `ADDR_SIZE and `INSTR_SIZE from xgriscv_defines.v.
REQ-024 SHALL add to xgriscv_defines.v the state encodings (IDLE=1'b0, WAIT=1'b1) and owner encodings (FETCH=1'b0, DATA=1'b1).
REQ-025 SHALL be a single module with no sub-modules; the round-robin selector is inline logic.

Verification
REQ-026 SHALL cover: MEM_LAT=1, i_req only, i_addr=0x10, m_rdata=0x00500093
- -> i_gnt and m_en in cycle N with m_addr=0x10.
- -> i_rvalid in N+1 with i_rdata=0x00500093.
REQ-027 SHALL cover: both request constantly after reset, MEM_LAT=1
- -> grants alternate FETCH, DATA, FETCH, DATA on consecutive cycles, first grant FETCH.
- -> each rvalid goes to the previous cycle's owner.
REQ-028 SHALL cover: MEM_LAT=3, d_req store, d_we=1, d_amp=4'b0100, d_addr=0x20, d_wdata=0xAB
- -> m_we=1, m_amp=4'b0100 only in the grant cycle.
- -> d_rvalid exactly 3 cycles later.
- -> no grant in between, even with i_req high.
REQ-029 SHALL cover: reset asserted one cycle after a fetch grant with MEM_LAT=2
- -> no i_rvalid ever for that fetch.
- -> after release, i_req=1 is granted in the first cycle, with m_en=1.
REQ-030 SHALL cover: d_req held high while i_req rises in the data completion cycle (MEM_LAT=1)
- -> fetch is granted in that cycle, since the last owner was DATA.
- -> data is granted in the next completion cycle.
REQ-031 SHALL cover: no requests for 5 cycles
- -> m_en=0, m_amp=0, and all gnt and rvalid outputs low in every cycle.
